// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the MIPS-lite multicycle main control FSM.
package mips_mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_NORI  = 6'b001110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NORI  = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Moore control-word decode from the current state; mem_ready gates the
// strobes of the cycles that wait on memory.
module mc_outdec
  import mips_mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      // Branch target precomputed while the opcode is decoded.
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH2;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite   = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_REX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
        ctrl.instr_done  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsource   = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_IEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_NORI;
      end
      S_IWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle main control FSM for the MIPS-lite datapath: state register,
// next-state logic and reset gating of the write/request strobes.
module mips_mc_ctrl
  import mips_mc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             aluop1,
  output logic             aluop0,
  output logic [1:0]       pcsource,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t state_q;
  state_t state_d;
  logic   illegal_c;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REX;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_NORI:      state_d = S_IEX;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_REX:    state_d = S_RWB;
      S_IEX:    state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Strobes are forced low while reset is held; selects keep FETCH values.
  assign pcwrite     = rst_n & ctrl.pcwrite;
  assign pcwritecond = rst_n & ctrl.pcwritecond;
  assign memread     = rst_n & ctrl.memread;
  assign memwrite    = rst_n & ctrl.memwrite;
  assign irwrite     = rst_n & ctrl.irwrite;
  assign regwrite    = rst_n & ctrl.regwrite;
  assign instr_done  = rst_n & ctrl.instr_done;
  assign illegal_op  = rst_n & illegal_c;

  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop1   = ctrl.aluop[1];
  assign aluop0   = ctrl.aluop[0];
  assign pcsource = ctrl.pcsource;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: per-cycle scoreboard against a
// reference model plus explicit state-sequence and reset checks.
module tb_mips_mc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, aluop1, aluop0;
  logic [1:0] alusrcb, pcsource;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          mstate   = 0;
  int          ill_cnt  = 0;
  logic [21:0] sb [$];
  int          hist [$];

  mips_mc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop1      (aluop1),
    .aluop0      (aluop0),
    .pcsource    (pcsource),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference output vector: {pw,pwc,iord,mrd,mwr,irw,m2r,rdst,rw,asa,asb,aop,psrc,done,ill,state}
  function automatic logic [21:0] model_out(int s, logic mr, logic [5:0] o);
    logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, done, ill;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, done, ill} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1:  begin asb = 2'b11;
                ill = !(o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
                        o == 6'b000100 || o == 6'b000010 || o == 6'b001110); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mwr = 1; io = 1; done = mr; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      9:  begin pw = 1; psrc = 2'b10; done = 1; end
      10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, done, ill, 4'(s)};
  endfunction

  function automatic int model_next(int s, logic mr, logic [5:0] o);
    case (s)
      0: return mr ? 1 : 0;
      1: begin
        if (o == 6'b100011 || o == 6'b101011) return 2;
        if (o == 6'b000000) return 6;
        if (o == 6'b000100) return 8;
        if (o == 6'b000010) return 9;
        if (o == 6'b001110) return 10;
        return 0;
      end
      2: return (o == 6'b100011) ? 3 : 5;
      3: return mr ? 4 : 3;
      5: return mr ? 0 : 5;
      6: return 7;
      10: return 11;
      default: return 0;
    endcase
  endfunction

  function automatic logic [21:0] dut_vec();
    return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
            regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource, instr_done, illegal_op, state};
  endfunction

  // One clock: drive, push expectation, compare at negedge, advance model.
  task automatic run_cycle(input logic [5:0] o, input logic mr);
    logic [21:0] exp;
    op = o;
    mem_ready = mr;
    sb.push_back(model_out(mstate, mr, o));
    @(negedge clk);
    exp = sb.pop_front();
    check("ctrl_word", 32'(dut_vec()), 32'(exp));
    check("rd_wr_excl", 32'(memread & memwrite), 32'd0);
    check("pc_excl", 32'(pcwrite & pcwritecond), 32'd0);
    hist.push_back(int'(state));
    ill_cnt += int'(illegal_op);
    mstate = model_next(mstate, mr, o);
    @(posedge clk);
    #1;
  endtask

  task automatic check_hist(input string tag, input int e[8], input int n);
    check({tag, "_len"}, 32'(hist.size()), 32'(n));
    for (int i = 0; i < n && i < hist.size(); i++)
      check(tag, 32'(hist[i]), 32'(e[i]));
    hist.delete();
  endtask

  initial begin
    rst_n = 1'b0; op = 6'd0; mem_ready = 1'b1;
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_memread", 32'(memread), 32'd0);
    check("rst_irwrite", 32'(irwrite), 32'd0);
    check("rst_pcwrite", 32'(pcwrite), 32'd0);
    check("rst_alusrcb", 32'(alusrcb), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // R-type
    for (int i = 0; i < 4; i++) run_cycle(6'b000000, 1'b1);
    check_hist("rtype_seq", '{0, 1, 6, 7, 0, 0, 0, 0}, 4);
    check("rtype_end", 32'(state), 32'd0);

    // LW with two stalled MEMRD cycles; op changes in MEMRD must be ignored
    run_cycle(6'b100011, 1'b1);
    run_cycle(6'b100011, 1'b1);
    run_cycle(6'b100011, 1'b1);
    run_cycle(6'b111111, 1'b0);
    run_cycle(6'b101011, 1'b0);
    run_cycle(6'b111111, 1'b1);
    run_cycle(6'b111111, 1'b1);
    check_hist("lw_seq", '{0, 1, 2, 3, 3, 3, 4, 0}, 7);
    check("lw_end", 32'(state), 32'd0);

    // BEQ
    for (int i = 0; i < 3; i++) run_cycle(6'b000100, 1'b1);
    check_hist("beq_seq", '{0, 1, 8, 0, 0, 0, 0, 0}, 3);

    // NORI
    for (int i = 0; i < 4; i++) run_cycle(6'b001110, 1'b1);
    check_hist("nori_seq", '{0, 1, 10, 11, 0, 0, 0, 0}, 4);

    // Illegal opcode
    ill_cnt = 0;
    for (int i = 0; i < 2; i++) run_cycle(6'b111111, 1'b1);
    check_hist("ill_seq", '{0, 1, 0, 0, 0, 0, 0, 0}, 2);
    check("ill_pulses", 32'(ill_cnt), 32'd1);
    check("ill_end", 32'(state), 32'd0);

    // SW with a stalled fetch and a stalled write
    run_cycle(6'b101011, 1'b0);
    run_cycle(6'b101011, 1'b1);
    run_cycle(6'b101011, 1'b1);
    run_cycle(6'b101011, 1'b1);
    run_cycle(6'b101011, 1'b0);
    run_cycle(6'b101011, 1'b1);
    check_hist("sw_seq", '{0, 0, 1, 2, 5, 5, 0, 0}, 6);

    // Jump
    for (int i = 0; i < 3; i++) run_cycle(6'b000010, 1'b1);
    check_hist("j_seq", '{0, 1, 9, 0, 0, 0, 0, 0}, 3);

    // Reset asserted mid-MEMRD with mem_ready high
    for (int i = 0; i < 3; i++) run_cycle(6'b100011, 1'b1);
    check("pre_rst_state", 32'(state), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_memread", 32'(memread), 32'd0);
    check("mid_rst_regwrite", 32'(regwrite), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_memread", 32'(memread), 32'd1);
    check("post_rst_irwrite", 32'(irwrite), 32'd1);
    mstate = 0;
    hist.delete();
    for (int i = 0; i < 4; i++) run_cycle(6'b000000, 1'b1);
    check_hist("post_rst_seq", '{0, 1, 6, 7, 0, 0, 0, 0}, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
